axis_uart_tx_framed: RTL

Parametrised AXI-Stream to UART transmitter with an integrated synchronous FIFO, runtime baud divisor, selectable stop bits, and packet-aware inter-frame idle gaps. It is the next-generation stream-to-serial egress block: upstream AXI-Stream masters push words, and the block serialises them LSB-first on a single TX line. Status outputs expose FIFO occupancy and line activity to the control plane.

---
 rtl/axis_uart_tx_framed.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_uart_tx_framed.sv
// AXI-Stream to UART transmitter with internal FIFO, runtime divisor, 1/2 stop bits and tlast gaps.
// Optional parity bit is compiled in when AXIS_UART_PARITY_EN is defined.
module axis_uart_tx_framed #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int GAP_BITS   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic                          cfg_stop2,
  input  logic                          cfg_parity_odd,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXB = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef AXIS_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    GAP
  } state_t;

  // FIFO
  logic [DATA_BITS:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      count;
  logic [DATA_BITS:0] head;
  logic               push, pop;

  state_t state, state_n;

  assign s_axis_tready = (count != FULL) && !rst;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = mem[rd_ptr];
  assign fifo_level    = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 last_q, last_n;
  logic                 stop2_q, stop2_n;
  logic [DIV_WIDTH-1:0] div_q, div_n;
  logic [DIV_WIDTH-1:0] baud_cnt, baud_n;
  logic [CW-1:0]        bitc, bitc_n;
  logic                 tx_q, tx_n;
  logic                 par_q, par_n;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [CW-1:0]        stop_last;
  logic                 tick;

  assign div_eff   = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
  assign tick      = (baud_cnt == '0);
  assign stop_last = {{(CW-1){1'b0}}, stop2_q};

`ifdef AXIS_UART_PARITY_EN
  assign par_n = pop ? ((^head[DATA_BITS-1:0]) ^ cfg_parity_odd) : par_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = cfg_parity_odd;
  assign par_n = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    last_n     = last_q;
    stop2_n    = stop2_q;
    div_n      = div_q;
    bitc_n     = bitc;
    baud_n     = tick ? div_q : baud_cnt - 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          shreg_n = head[DATA_BITS-1:0];
          last_n  = head[DATA_BITS];
          stop2_n = cfg_stop2;
          div_n   = div_eff;
          baud_n  = div_eff;
          bitc_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          bitc_n  = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          if (bitc == CW'(DATA_BITS - 1)) begin
            bitc_n = '0;
`ifdef AXIS_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
`ifdef AXIS_UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          bitc_n  = '0;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bitc == stop_last) begin
            frame_done = 1'b1;
            bitc_n     = '0;
            state_n    = (last_q && (GAP_BITS > 0)) ? GAP : IDLE;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (bitc == CW'(GAP_BITS - 1)) begin
            bitc_n  = '0;
            state_n = IDLE;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is registered from the next state so uart_tx is glitch-free.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef AXIS_UART_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      last_q   <= 1'b0;
      stop2_q  <= 1'b0;
      div_q    <= '0;
      baud_cnt <= '0;
      bitc     <= '0;
      tx_q     <= 1'b1;
      par_q    <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      last_q   <= last_n;
      stop2_q  <= stop2_n;
      div_q    <= div_n;
      baud_cnt <= baud_n;
      bitc     <= bitc_n;
      tx_q     <= tx_n;
      par_q    <= par_n;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (state != IDLE);

endmodule
